// File: rtl/graphics_pkg.sv
// graphics_pkg -- shared definitions for the command sequencer.
//   OP_CLEAR / OP_ASSIGN_COLOR / OP_SHOW : command opcodes
//   state_t                              : sequencer state encoding
//   FB_PIXELS_DEFAULT                    : frame-buffer size (640x400)
//   pack_color()                         : builds the 10-bit {Y,Cb,Cr} palette word
package graphics_pkg;

    localparam logic [7:0] OP_CLEAR        = 8'h10;
    localparam logic [7:0] OP_ASSIGN_COLOR = 8'h11;
    localparam logic [7:0] OP_SHOW         = 8'h12;

    localparam int FB_PIXELS_DEFAULT = 256000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CLEAR,
        ST_SWITCH_WAIT
    } state_t;

    function automatic logic [9:0] pack_color(input logic [3:0] y,
                                              input logic [2:0] cb,
                                              input logic [2:0] cr);
        return {y, cb, cr};
    endfunction

endpackage

// File: rtl/command_sequencer_if.sv
// command_sequencer_if -- command input and pixel/palette output bundle.
//   op_code_in/op_code_valid_in      : command byte + 1-cycle strobe
//   operand_in/operand_valid_in      : operand byte + 1-cycle strobe
//   pixel_write_*                    : frame-buffer write port
//   pixel_write_buffer_ready_in      : buffer swap allowed
//   switch_write_buffer_out          : 1-cycle swap request
//   assign_color_*                   : palette write port
//   busy_out / dropped_out           : status
// Modports: master = command source / sink of results, slave = sequencer.
interface command_sequencer_if #(
    parameter int ADDR_WIDTH = 18
);
    logic [7:0]            op_code_in;
    logic                  op_code_valid_in;
    logic [7:0]            operand_in;
    logic                  operand_valid_in;
    logic [ADDR_WIDTH-1:0] pixel_write_address_out;
    logic [3:0]            pixel_write_data_out;
    logic                  pixel_write_enable_out;
    logic                  pixel_write_buffer_ready_in;
    logic                  switch_write_buffer_out;
    logic                  assign_color_enable_out;
    logic [3:0]            assign_color_index_out;
    logic [9:0]            assign_color_value_out;
    logic                  busy_out;
    logic                  dropped_out;

    modport master (
        output op_code_in, op_code_valid_in, operand_in, operand_valid_in,
        output pixel_write_buffer_ready_in,
        input  pixel_write_address_out, pixel_write_data_out, pixel_write_enable_out,
        input  switch_write_buffer_out,
        input  assign_color_enable_out, assign_color_index_out, assign_color_value_out,
        input  busy_out, dropped_out
    );

    modport slave (
        input  op_code_in, op_code_valid_in, operand_in, operand_valid_in,
        input  pixel_write_buffer_ready_in,
        output pixel_write_address_out, pixel_write_data_out, pixel_write_enable_out,
        output switch_write_buffer_out,
        output assign_color_enable_out, assign_color_index_out, assign_color_value_out,
        output busy_out, dropped_out
    );
endinterface

// File: rtl/fill_address_generator.sv
// fill_address_generator -- walks address 0..count-1, one per cycle.
//   clock_in, reset_n_in : clock, synchronous active-low reset
//   start                : begin a new sweep (address 0 visible next cycle)
//   count                : number of addresses in a sweep
//   address, enable      : registered write address and strobe
//   done                 : high in the cycle the final address is presented
module fill_address_generator #(
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] count,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  enable,
    output logic                  done
);

    assign done = enable && (address == count - 1'b1);

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            enable  <= 1'b0;
            address <= '0;
        end else if (start) begin
            enable  <= 1'b1;
            address <= '0;
        end else if (done) begin
            // Address parks at 0 once the sweep ends.
            enable  <= 1'b0;
            address <= '0;
        end else if (enable) begin
            address <= address + 1'b1;
        end
    end

endmodule

// File: rtl/command_sequencer.sv
// command_sequencer -- decodes a byte command stream into frame-buffer
// clears, palette writes and buffer-swap requests.
//   clock_in    : system clock (rising edge)
//   reset_n_in  : synchronous active-low reset
//   bus         : command_sequencer_if.slave (commands in, writes/status out)
// Build option: CMD_SEQ_FILL_OPERAND_EN -- when defined, CLEAR takes one
// operand whose low nibble is the fill index; otherwise CLEAR fills with 0.
module command_sequencer
    import graphics_pkg::*;
#(
    parameter int FB_PIXELS  = FB_PIXELS_DEFAULT,
    parameter int ADDR_WIDTH = 18
) (
    input  logic               clock_in,
    input  logic               reset_n_in,
    command_sequencer_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] FILL_COUNT = ADDR_WIDTH'(FB_PIXELS);

    state_t                state;
    logic [1:0]            operand_count;
    logic [3:0]            color_index;
    logic [3:0]            color_y;
    logic [2:0]            color_cb;
    logic                  op_accept;
    logic                  operand_accept;
    logic                  fill_operand_pending;
    logic                  fill_start;
    logic                  fill_done;
    logic                  fill_enable;
    logic [ADDR_WIDTH-1:0] fill_address;
    logic [3:0]            fill_index_next;

    // An opcode in COLLECT resynchronises: it is decoded exactly as in IDLE.
    assign op_accept      = bus.op_code_valid_in &&
                            (state == ST_IDLE || state == ST_COLLECT);
    // An opcode in the same cycle wins over the operand.
    assign operand_accept = bus.operand_valid_in && !bus.op_code_valid_in &&
                            (state == ST_COLLECT);

`ifdef CMD_SEQ_FILL_OPERAND_EN
    logic collect_fill;
    assign fill_operand_pending = collect_fill;
    assign fill_start           = operand_accept && collect_fill;
    assign fill_index_next      = bus.operand_in[3:0];
`else
    assign fill_operand_pending = 1'b0;
    assign fill_start           = op_accept && (bus.op_code_in == OP_CLEAR);
    assign fill_index_next      = 4'd0;
`endif

    fill_address_generator #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fill (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .start      (fill_start),
        .count      (FILL_COUNT),
        .address    (fill_address),
        .enable     (fill_enable),
        .done       (fill_done)
    );

    assign bus.pixel_write_address_out = fill_address;
    assign bus.pixel_write_enable_out  = fill_enable;

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state                        <= ST_IDLE;
            operand_count                <= 2'd0;
            color_index                  <= 4'd0;
            color_y                      <= 4'd0;
            color_cb                     <= 3'd0;
`ifdef CMD_SEQ_FILL_OPERAND_EN
            collect_fill                 <= 1'b0;
`endif
            bus.pixel_write_data_out     <= 4'd0;
            bus.switch_write_buffer_out  <= 1'b0;
            bus.assign_color_enable_out  <= 1'b0;
            bus.assign_color_index_out   <= 4'd0;
            bus.assign_color_value_out   <= 10'd0;
            bus.busy_out                 <= 1'b0;
            bus.dropped_out              <= 1'b0;
        end else begin
            bus.assign_color_enable_out <= 1'b0;
            bus.switch_write_buffer_out <= 1'b0;
            if (fill_start) begin
                bus.pixel_write_data_out <= fill_index_next;
            end

            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (op_accept) begin
                        operand_count <= 2'd0;
                        case (bus.op_code_in)
                            OP_CLEAR: begin
`ifdef CMD_SEQ_FILL_OPERAND_EN
                                state        <= ST_COLLECT;
                                collect_fill <= 1'b1;
`else
                                state        <= ST_CLEAR;
`endif
                                bus.busy_out <= 1'b1;
                            end
                            OP_ASSIGN_COLOR: begin
                                state        <= ST_COLLECT;
`ifdef CMD_SEQ_FILL_OPERAND_EN
                                collect_fill <= 1'b0;
`endif
                                bus.busy_out <= 1'b1;
                            end
                            OP_SHOW: begin
                                state        <= ST_SWITCH_WAIT;
                                bus.busy_out <= 1'b1;
                            end
                            default: begin
                                // No-op in IDLE; abandons a partial collection.
                                state        <= ST_IDLE;
                                bus.busy_out <= 1'b0;
                            end
                        endcase
                    end else if (operand_accept) begin
                        if (fill_operand_pending) begin
                            state <= ST_CLEAR;
                        end else begin
                            operand_count <= operand_count + 2'd1;
                            case (operand_count)
                                2'd0:    color_index <= bus.operand_in[3:0];
                                2'd1:    color_y     <= bus.operand_in[7:4];
                                2'd2:    color_cb    <= bus.operand_in[7:5];
                                default: begin
                                    bus.assign_color_enable_out <= 1'b1;
                                    bus.assign_color_index_out  <= color_index;
                                    bus.assign_color_value_out  <=
                                        pack_color(color_y, color_cb, bus.operand_in[7:5]);
                                    operand_count <= 2'd0;
                                    state         <= ST_IDLE;
                                    bus.busy_out  <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
                ST_CLEAR: begin
                    if (bus.op_code_valid_in) begin
                        bus.dropped_out <= 1'b1;
                    end
                    if (fill_done) begin
                        state        <= ST_IDLE;
                        bus.busy_out <= 1'b0;
                    end
                end
                ST_SWITCH_WAIT: begin
                    if (bus.op_code_valid_in) begin
                        bus.dropped_out <= 1'b1;
                    end
                    if (bus.pixel_write_buffer_ready_in) begin
                        bus.switch_write_buffer_out <= 1'b1;
                        state                       <= ST_IDLE;
                        bus.busy_out                <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    bus.busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_command_sequencer.sv
// tb_command_sequencer -- directed plus randomized bench for command_sequencer.
// A reduced frame buffer keeps full CLEAR sweeps short.
module tb_command_sequencer;

    localparam int FB = 1200;
    localparam int AW = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    command_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    command_sequencer #(
        .FB_PIXELS  (FB),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    int checks = 0;
    int failures = 0;

    // Event monitor: counts strobes and checks write address/data sequence.
    int         n_write = 0;
    int         n_assign = 0;
    int         n_switch = 0;
    int         wr_bad = 0;
    int         busy_bad = 0;
    int         exp_addr = 0;
    logic [3:0] exp_fill = 4'd0;

    always @(negedge clk) begin
        if (bus.pixel_write_enable_out === 1'b1) begin
            n_write <= n_write + 1;
            if (bus.pixel_write_address_out !== AW'(exp_addr) ||
                bus.pixel_write_data_out !== exp_fill)
                wr_bad <= wr_bad + 1;
            if (bus.busy_out !== 1'b1)
                busy_bad <= busy_bad + 1;
            exp_addr <= (exp_addr == FB - 1) ? 0 : exp_addr + 1;
        end else if (!rst_n) begin
            exp_addr <= 0;
        end
        if (bus.assign_color_enable_out === 1'b1) n_assign <= n_assign + 1;
        if (bus.switch_write_buffer_out === 1'b1) n_switch <= n_switch + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Palette word from the component rules: Y top nibble, Cb/Cr top 3 bits.
    function automatic logic [31:0] model_color(input int y, input int cb, input int cr);
        return 32'((y / 16) * 64 + (cb / 32) * 8 + (cr / 32));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [7:0] b);
        bus.op_code_in       = b;
        bus.op_code_valid_in = 1'b1;
        tick();
        bus.op_code_valid_in = 1'b0;
    endtask

    task automatic send_operand(input logic [7:0] b);
        bus.operand_in       = b;
        bus.operand_valid_in = 1'b1;
        tick();
        bus.operand_valid_in = 1'b0;
    endtask

    task automatic send_both(input logic [7:0] op, input logic [7:0] opd);
        bus.op_code_in       = op;
        bus.operand_in       = opd;
        bus.op_code_valid_in = 1'b1;
        bus.operand_valid_in = 1'b1;
        tick();
        bus.op_code_valid_in = 1'b0;
        bus.operand_valid_in = 1'b0;
    endtask

    // Operands after the opcode; checks the strobe one cycle after the 4th.
    task automatic assign_operands(input string tag, input logic [7:0] a, input logic [7:0] y,
                                   input logic [7:0] cb, input logic [7:0] cr);
        int base = n_assign;
        send_operand(a);
        send_operand(y);
        send_operand(cb);
        send_operand(cr);
        check({tag, "_en"}, 32'(bus.assign_color_enable_out), 1);
        check({tag, "_idx"}, 32'(bus.assign_color_index_out), 32'(int'(a) % 16));
        check({tag, "_val"}, 32'(bus.assign_color_value_out), model_color(int'(y), int'(cb), int'(cr)));
        tick();
        check({tag, "_en_drop"}, 32'(bus.assign_color_enable_out), 0);
        check({tag, "_busy_idle"}, 32'(bus.busy_out), 0);
        check({tag, "_count"}, 32'(n_assign - base), 1);
    endtask

    task automatic start_clear();
`ifdef CMD_SEQ_FILL_OPERAND_EN
        logic [7:0] b;
        b[7:4]   = 4'($urandom);
        b[3:0]   = 4'($urandom);
        exp_fill = b[3:0];
        send_op(8'h10);
        send_operand(b);
`else
        exp_fill = 4'd0;
        send_op(8'h10);
`endif
        check("clear_first_en", 32'(bus.pixel_write_enable_out), 1);
        check("clear_first_addr", 32'(bus.pixel_write_address_out), 0);
        check("clear_first_busy", 32'(bus.busy_out), 1);
    endtask

    task automatic wait_write_addr(input int a);
        int n = 0;
        while (!(bus.pixel_write_enable_out === 1'b1 &&
                 bus.pixel_write_address_out === AW'(a)) && n < FB + 20) begin
            tick();
            n++;
        end
        check("reach_addr", 32'(bus.pixel_write_address_out), 32'(a));
    endtask

    task automatic wait_fill_end();
        int n = 0;
        while (bus.pixel_write_enable_out === 1'b1 && n < FB + 20) begin
            tick();
            n++;
        end
        check("fill_end_en", 32'(bus.pixel_write_enable_out), 0);
        check("fill_end_busy", 32'(bus.busy_out), 0);
        check("fill_end_addr", 32'(bus.pixel_write_address_out), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, 32'(bus.pixel_write_enable_out), 0);
        check({tag, "_addr"}, 32'(bus.pixel_write_address_out), 0);
        check({tag, "_data"}, 32'(bus.pixel_write_data_out), 0);
        check({tag, "_switch"}, 32'(bus.switch_write_buffer_out), 0);
        check({tag, "_aen"}, 32'(bus.assign_color_enable_out), 0);
        check({tag, "_aidx"}, 32'(bus.assign_color_index_out), 0);
        check({tag, "_aval"}, 32'(bus.assign_color_value_out), 0);
        check({tag, "_busy"}, 32'(bus.busy_out), 0);
        check({tag, "_dropped"}, 32'(bus.dropped_out), 0);
    endtask

    initial begin
        int bw, bb, bs, ba, bsw;
        logic [7:0] r [4];
        logic [7:0] op;

        bus.op_code_in                  = 8'h00;
        bus.op_code_valid_in            = 1'b0;
        bus.operand_in                  = 8'h00;
        bus.operand_valid_in            = 1'b0;
        bus.pixel_write_buffer_ready_in = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Fixed palette vector
        send_op(8'h11);
        assign_operands("assign_fixed", 8'h03, 8'hF0, 8'hA0, 8'h40);
        check("assign_fixed_word", 32'(bus.assign_color_value_out), 32'(10'b1111_101_010));

        // Randomized palette writes
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) r[k] = 8'($urandom);
            send_op(8'h11);
            assign_operands("assign_rand", r[0], r[1], r[2], r[3]);
        end

        // Unknown opcodes and stray operands in IDLE are ignored
        ba = n_assign;
        for (int i = 0; i < 4; i++) begin
            do op = 8'($urandom); while (op >= 8'h10 && op <= 8'h12);
            send_op(op);
            check("ignored_op_busy", 32'(bus.busy_out), 0);
            check("ignored_op_dropped", 32'(bus.dropped_out), 0);
            send_operand(8'($urandom));
        end
        tick();
        check("stray_operand_assign", 32'(n_assign - ba), 0);

        // Opcode and operand in one cycle: operand is not collected
        send_both(8'h11, 8'hFF);
        assign_operands("same_cycle", 8'h05, 8'h80, 8'h40, 8'hE0);

        // Full CLEAR
        bw = n_write; bb = wr_bad; bs = busy_bad;
        start_clear();
        wait_fill_end();
        check("clear_writes", 32'(n_write - bw), 32'(FB));
        check("clear_order", 32'(wr_bad - bb), 0);
        check("clear_busy_hi", 32'(busy_bad - bs), 0);

        // SHOW with ready held low 50 cycles
        bsw = n_switch;
        send_op(8'h12);
        check("show_busy", 32'(bus.busy_out), 1);
        repeat (50) tick();
        check("show_wait_no_pulse", 32'(n_switch - bsw), 0);
        bus.pixel_write_buffer_ready_in = 1'b1;
        tick();
        check("show_pulse", 32'(bus.switch_write_buffer_out), 1);
        bus.pixel_write_buffer_ready_in = 1'b0;
        tick();
        check("show_pulse_end", 32'(bus.switch_write_buffer_out), 0);
        check("show_idle", 32'(bus.busy_out), 0);
        check("show_count", 32'(n_switch - bsw), 1);

        // SHOW with a random wait
        bsw = n_switch;
        send_op(8'h12);
        repeat ($urandom_range(0, 30)) tick();
        bus.pixel_write_buffer_ready_in = 1'b1;
        tick();
        check("show_rand_pulse", 32'(bus.switch_write_buffer_out), 1);
        bus.pixel_write_buffer_ready_in = 1'b0;
        tick();
        check("show_rand_count", 32'(n_switch - bsw), 1);

        // SHOW during CLEAR is dropped; fill completes
        bw = n_write; bb = wr_bad; bsw = n_switch;
        bus.pixel_write_buffer_ready_in = 1'b1;
        start_clear();
        wait_write_addr(1000);
        send_op(8'h12);
        check("drop_flag", 32'(bus.dropped_out), 1);
        wait_fill_end();
        repeat (5) tick();
        bus.pixel_write_buffer_ready_in = 1'b0;
        check("drop_writes", 32'(n_write - bw), 32'(FB));
        check("drop_order", 32'(wr_bad - bb), 0);
        check("drop_no_switch", 32'(n_switch - bsw), 0);
        check("drop_sticky", 32'(bus.dropped_out), 1);

        // Opcode mid-collection resyncs to SHOW
        ba = n_assign; bsw = n_switch;
        send_op(8'h11);
        send_operand(8'h07);
        send_operand(8'h70);
        send_op(8'h12);
        check("resync_busy", 32'(bus.busy_out), 1);
        check("resync_dropped", 32'(bus.dropped_out), 1);
        bus.pixel_write_buffer_ready_in = 1'b1;
        tick();
        check("resync_switch", 32'(bus.switch_write_buffer_out), 1);
        bus.pixel_write_buffer_ready_in = 1'b0;
        send_operand(8'h11);
        send_operand(8'h22);
        tick();
        check("resync_no_assign", 32'(n_assign - ba), 0);

        // ASSIGN restarted by a new ASSIGN opcode
        send_op(8'h11);
        send_operand(8'h0C);
        send_op(8'h11);
        assign_operands("restart", 8'h09, 8'h30, 8'hC0, 8'h20);

        // Reset mid-collection
        ba = n_assign;
        send_op(8'h11);
        send_operand(8'h01);
        send_operand(8'h02);
        rst_n = 1'b0;
        tick();
        check("rst_collect_busy", 32'(bus.busy_out), 0);
        check("rst_collect_dropped", 32'(bus.dropped_out), 0);
        rst_n = 1'b1;
        tick();
        send_operand(8'h03);
        send_operand(8'h04);
        tick();
        check("rst_collect_no_assign", 32'(n_assign - ba), 0);

        // Reset mid-CLEAR at address 500
        bw = n_write;
        start_clear();
        wait_write_addr(500);
        rst_n = 1'b0;
        tick();
        check_all_zero("rst_clear");
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("rst_clear_writes", 32'(n_write - bw), 501);
        check("rst_clear_idle_en", 32'(bus.pixel_write_enable_out), 0);

        // Sequencer usable after reset
        send_op(8'h11);
        assign_operands("post_reset", 8'h0F, 8'hFF, 8'hFF, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/command_sequencer.md
COMMAND_SEQUENCER -- requirements
Module: command_sequencer

Interface
REQ-001 Parameter FB_PIXELS, default 256000, number of frame-buffer pixels filled by CLEAR (640x400).
REQ-002 Parameter ADDR_WIDTH, default 18, width of the pixel write address.
REQ-003 clock_in  input  1  single system clock; all logic is on its rising edge.
REQ-004 reset_n_in  input  1  synchronous, active-low reset.
REQ-005 op_code_in  input  8  command byte; op_code_valid_in  input  1  one-cycle strobe qualifying op_code_in.
REQ-006 operand_in  input  8  operand byte; operand_valid_in  input  1  one-cycle strobe qualifying operand_in.
REQ-007 pixel_write_address_out  output  ADDR_WIDTH  write address; pixel_write_data_out  output  4  palette index; pixel_write_enable_out  output  1  write strobe.
REQ-008 pixel_write_buffer_ready_in  input  1  write buffer may be swapped; switch_write_buffer_out  output  1  one-cycle swap request.
REQ-009 assign_color_enable_out  output  1  palette write strobe; assign_color_index_out  output  4; assign_color_value_out  output  10  {Y[3:0],Cb[2:0],Cr[2:0]}.
REQ-010 busy_out  output  1  high whenever state is not IDLE; dropped_out  output  1  sticky flag, an opcode was discarded.

Function
REQ-011 States SHALL be IDLE, COLLECT, CLEAR, SWITCH_WAIT.
REQ-012 Opcode 0x10 CLEAR: IDLE -> CLEAR (or -> COLLECT when the fill operand is configured, REQ-027).
REQ-013 Opcode 0x11 ASSIGN_COLOR: IDLE -> COLLECT expecting 4 operands: index, Y, Cb, Cr.
REQ-014 Opcode 0x12 SHOW: IDLE -> SWITCH_WAIT.
REQ-015 Any other opcode in IDLE SHALL be ignored with no state change and no dropped_out.
REQ-016 ASSIGN_COLOR: the cycle after the 4th operand strobe, assign_color_enable_out high for exactly 1 cycle, index = op1[3:0], value = {op2[7:4],op3[7:5],op4[7:5]}; next state IDLE.
REQ-017 CLEAR: beginning the cycle after entry, pixel_write_enable_out high every cycle, address 0,1,...,FB_PIXELS-1, data = fill index; after address FB_PIXELS-1 -> IDLE; enable low the following cycle; address returns to 0.
REQ-018 SWITCH_WAIT: first cycle pixel_write_buffer_ready_in is high, switch_write_buffer_out pulses 1 cycle, then IDLE; wait is unbounded.
REQ-019 Opcode strobe in CLEAR or SWITCH_WAIT SHALL be discarded and set dropped_out; active operation continues unaffected.
REQ-020 Opcode strobe in COLLECT SHALL abort the pending collection and be decoded as if in IDLE (resync); dropped_out unchanged.
REQ-021 Operand strobe outside COLLECT SHALL be ignored.
REQ-022 Opcode and operand strobes in the same cycle: opcode handled, operand ignored.
REQ-023 Outputs SHALL be registered; pixel_write_data_out and assign_* values are don't-care when their strobe is low but SHALL hold 0 after reset.

Reset
REQ-024 On reset_n_in low at a clock edge: state IDLE, operand count 0, all outputs 0, dropped_out cleared.
REQ-025 Reset mid-CLEAR or mid-COLLECT SHALL terminate the operation; no further strobes after the reset edge.

Configuration
REQ-026 Macro CMD_SEQ_FILL_OPERAND_EN selects the CLEAR fill source.
REQ-027 Defined: CLEAR enters COLLECT for 1 operand, fill index = operand[3:0], fill starts the cycle after that operand strobe.
REQ-028 Undefined: CLEAR takes no operands, fill index is 0.

Structure
REQ-029 Package graphics_pkg SHALL hold opcode constants (OP_CLEAR, OP_ASSIGN_COLOR, OP_SHOW), the state enum and FB_PIXELS_DEFAULT.
REQ-030 One sub-module fill_address_generator (start, count, address, enable, done) is natural; the rest stays in command_sequencer.

Verification
REQ-031 0x11 then operands 0x03,0xF0,0xA0,0x40 -> one assign strobe, index 3, value 10'b1111_101_010.
REQ-032 0x10 (macro off) -> 256000 consecutive writes, address 0..255999, data 0, busy_out high throughout, low the cycle after the last write.
REQ-033 0x12 with ready low for 50 cycles then high -> switch_write_buffer_out pulses exactly once, the cycle after ready rises.
REQ-034 0x12 during CLEAR at address 1000 -> ignored, dropped_out=1, fill completes to 255999, no switch pulse.
REQ-035 0x11 plus 2 operands then 0x12 -> no assign strobe, SHOW executes; reset asserted at CLEAR address 500 -> enable low from the next cycle, all outputs 0.
